car_sprite_blitter: RTL and testbench
=====================================

# car_sprite_blitter

Copies one car sprite frame out of the palette-decoded car sprite ROM into the frame buffer, pixel by pixel. It sits between game logic and the frame-buffer write port, and drives the ROM's `read_address`/`Clk` interface as the reading master. The frame is selected by the remaining-lives count. Palette-white pixels are treated as transparent, and pixels outside the 640x480 screen are clipped.

## Interface

**Parameters**
- `SPRITE_W`, default 80: sprite width in pixels.
- `SPRITE_H`, default 104: sprite height in pixels.
- `SCREEN_W`, default 640: frame-buffer width.
- `SCREEN_H`, default 480: frame-buffer height.
- `TRANSPARENT`, default 24'hffffff: colour that is never written.

**Ports**
- `Clk` in 1: single system clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to blit. Sampled only in IDLE.
- `lives` in 3: frame select. Valid range is 1..5.
- `pos_x` in 10: screen X of the sprite's top-left pixel.
- `pos_y` in 9: screen Y of the sprite's top-left pixel.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse at completion.
- `err` out 1: one-cycle pulse, coincident with `done`, when `lives` is invalid.
- `rom_addr` out 16: drives the ROM `read_address`.
- `rom_data` in 24: ROM `data_out`. Valid the cycle after `rom_addr` is presented.
- `fb_addr` out 19: write address, equal to y*SCREEN_W + x.
- `fb_data` out 24: write pixel.
- `fb_we` out 1: write strobe.
- `fb_ready` in 1: the frame buffer accepts a write when high. When low, the blitter stalls.

## Operation

**States:** IDLE, FETCH, DRAIN, FIN.

**IDLE**
- On `start` with `lives` in 1..5:
  - latch `lives`, `pos_x`, `pos_y`;
  - set frame base = (5 - lives) * 8320 (16-bit);
  - clear `row` and `col`;
  - go to FETCH.
- On `start` with an invalid `lives`: go to FIN with `err` set.

**FETCH**
- `rom_addr` = base + row*SPRITE_W + col.
- Each advancing cycle increments `col`. When `col` reaches SPRITE_W-1, `col` wraps to 0 and `row` increments.
- After issuing the address for row SPRITE_H-1, col SPRITE_W-1, go to DRAIN.

**Write stage (runs one cycle behind FETCH)**
- Holds the previous cycle's row and col and a valid bit.
- Write condition: valid, `rom_data` != TRANSPARENT, pos_x+col < SCREEN_W, and pos_y+row < SCREEN_H. When all hold, assert `fb_we` with `fb_addr` = (pos_y+row)*SCREEN_W + (pos_x+col) and `fb_data` = `rom_data`.
- Sum widths: X sum is 11 bits and Y sum is 10 bits. These widths allow no wrap-around, so off-screen pixels are dropped rather than wrapped.

**DRAIN**
- Completes the final write, then goes to FIN.

**FIN**
- Pulses `done` (and `err` if the request was invalid), then returns to IDLE.

**Stall behaviour**
- A stall occurs when `fb_we` would be asserted and `fb_ready` = 0.
- During a stall, hold `rom_addr`, the counters, the write-stage registers and `fb_*` outputs.
- The ROM re-reads the same address, so `rom_data` stays valid.
- Transparent or clipped pixels never stall.

**Other rules**
- A `start` received while not in IDLE is ignored.
- Input changes after acceptance have no effect.
- When `Reset_n` is asserted mid-blit, all outputs go to their reset values immediately and the partial write is abandoned.

## Timing

- **Reset values:** state IDLE; `busy`, `done`, `err`, `fb_we` = 0; `rom_addr`, `fb_addr`, `fb_data` = 0.
- **Acceptance:** `start` is accepted at cycle 0. The first `rom_addr` appears in cycle 1 and the first `fb_we` can occur in cycle 2.
- **Unstalled latency:** with no stalls, the last address issues in cycle 8320, the last write in cycle 8321, and `done` in cycle 8322. `busy` is high in cycles 1..8321.
- **Stall cost:** each stalled cycle adds exactly one cycle.
- **Invalid `lives`:** `done` and `err` pulse in cycle 1, `busy` stays 0, and there are no ROM or frame-buffer writes.
- **ROM read latency:** exactly 1 cycle (registered read followed by combinational palette decode). The ROM latency is fixed, so no valid handshake comes from the ROM.

## Structure

- **Shared package `sprite_pkg`:**
  - `SPRITE_W`, `SPRITE_H`, `FRAME_WORDS` = 8320, `NUM_FRAMES` = 5;
  - `SCREEN_W`, `SCREEN_H`, `TRANSPARENT`;
  - `typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} blit_state_t`.
- **Sub-module `sprite_addr_gen`:** owns the row/col counters, the advance input and the last flag, and computes the linear ROM address from the frame base. The top level owns the FSM, the write stage and clipping.

## Test plan

- **Full-frame blit:** `lives`=5, pos=(0,0), ROM model returns a non-white index pattern, `fb_ready`=1 → 8320 writes; the first has `fb_addr` 0; the write for row 1 col 0 has `fb_addr` 640; `done` in cycle 8322.
- **Frame select:** `lives`=1 → first `rom_addr` is 33280 and last is 41599. `lives`=3 → first is 16640.
- **Clipping and transparency:** pos=(600,450), ROM all index 1 → only cols 0..39 of rows 0..29 are written (1200 writes). Repeat with the ROM all white (index 0) → 0 writes, `done` still in cycle 8322.
- **Backpressure:** toggle `fb_ready` randomly at 50% → all 8320 writes are correct and in order; `rom_addr`/`fb_*` are held during stall cycles; `done` is delayed by exactly the number of stall cycles.
- **Invalid and overlapping requests:** `lives`=0 and `lives`=6 → `done`+`err` in cycle 1 with no writes. A `start` pulse mid-blit → ignored, and the write count is unchanged.
- **Reset mid-blit:** assert `Reset_n`=0 at cycle 4000 → all outputs are 0 within the same cycle. A fresh `start` after release completes a normal 8320-write blit.

Source files
------------

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants, state type and helpers for the car sprite blitter
package sprite_pkg;

  localparam int          SPRITE_W    = 80;
  localparam int          SPRITE_H    = 104;
  localparam int          FRAME_WORDS = SPRITE_W * SPRITE_H;
  localparam int          NUM_FRAMES  = 5;
  localparam int          SCREEN_W    = 640;
  localparam int          SCREEN_H    = 480;
  localparam logic [23:0] TRANSPARENT = 24'hffffff;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} blit_state_t;

  function automatic logic lives_valid(input logic [2:0] lives);
    return (lives >= 3'd1) && (lives <= 3'(NUM_FRAMES));
  endfunction

  // The five-lives car sits at the start of the ROM; each lost life steps one frame further in.
  function automatic logic [15:0] frame_base(input logic [2:0] lives, input int unsigned words);
    logic [31:0] idx;
    idx = 32'(NUM_FRAMES) - 32'(lives);
    return 16'(idx * words);
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// rtl/sprite_addr_gen.sv - row/column walk over one sprite frame and the matching ROM address
module sprite_addr_gen #(
  parameter int SPRITE_W = sprite_pkg::SPRITE_W,
  parameter int SPRITE_H = sprite_pkg::SPRITE_H,
  localparam int CW = $clog2(SPRITE_W),
  localparam int RW = $clog2(SPRITE_H)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          advance_i,
  input  logic [15:0]   base_i,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          last_o,
  output logic [15:0]   addr_o
);
  import sprite_pkg::*;

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          col_wrap;

  assign col_wrap = (col_q == CW'(SPRITE_W - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = col_wrap && (row_q == RW'(SPRITE_H - 1));
  assign addr_o = base_i + 16'(row_q) * 16'(SPRITE_W) + 16'(col_q);

endmodule

// File: rtl/car_sprite_blitter.sv
// rtl/car_sprite_blitter.sv - copies one lives-selected car frame from the sprite ROM into the frame buffer
module car_sprite_blitter #(
  parameter int          SPRITE_W    = sprite_pkg::SPRITE_W,
  parameter int          SPRITE_H    = sprite_pkg::SPRITE_H,
  parameter int          SCREEN_W    = sprite_pkg::SCREEN_W,
  parameter int          SCREEN_H    = sprite_pkg::SCREEN_H,
  parameter logic [23:0] TRANSPARENT = sprite_pkg::TRANSPARENT
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic [2:0]  lives,
  input  logic [9:0]  pos_x,
  input  logic [8:0]  pos_y,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rom_addr,
  input  logic [23:0] rom_data,
  output logic [18:0] fb_addr,
  output logic [23:0] fb_data,
  output logic        fb_we,
  input  logic        fb_ready
);
  import sprite_pkg::*;

  localparam int CW = $clog2(SPRITE_W);
  localparam int RW = $clog2(SPRITE_H);

  blit_state_t   state_q, state_d;
  logic [15:0]   base_q, base_d;
  logic [9:0]    pos_x_q, pos_x_d;
  logic [8:0]    pos_y_q, pos_y_d;
  logic          err_q, err_d;
  logic          wr_valid_q, wr_valid_d;
  logic [RW-1:0] wr_row_q, wr_row_d;
  logic [CW-1:0] wr_col_q, wr_col_d;
  logic [15:0]   wr_raddr_q, wr_raddr_d;

  logic          accept;
  logic          stall;
  logic          cnt_advance;
  logic [RW-1:0] cnt_row;
  logic [CW-1:0] cnt_col;
  logic          cnt_last;
  logic [15:0]   cnt_addr;
  logic [10:0]   x_sum;
  logic [9:0]    y_sum;
  logic          on_screen;
  logic [18:0]   lin_addr;

  assign accept      = (state_q == IDLE) && start && lives_valid(lives);
  assign cnt_advance = (state_q == FETCH) && !stall && !cnt_last;

  sprite_addr_gen #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_addr_gen (
    .clk_i     (Clk),
    .rst_ni    (Reset_n),
    .clear_i   (accept),
    .advance_i (cnt_advance),
    .base_i    (base_q),
    .row_o     (cnt_row),
    .col_o     (cnt_col),
    .last_o    (cnt_last),
    .addr_o    (cnt_addr)
  );

  // Sums are one bit wider than the screen coordinates, so off-screen pixels clip instead of wrapping.
  assign x_sum     = 11'(pos_x_q) + 11'(wr_col_q);
  assign y_sum     = 10'(pos_y_q) + 10'(wr_row_q);
  assign on_screen = (x_sum < 11'(SCREEN_W)) && (y_sum < 10'(SCREEN_H));
  assign lin_addr  = 19'(y_sum) * 19'(SCREEN_W) + 19'(x_sum);

  assign fb_we   = wr_valid_q && (rom_data != TRANSPARENT) && on_screen;
  assign stall   = fb_we && !fb_ready;
  assign fb_addr = fb_we ? lin_addr : '0;
  assign fb_data = fb_we ? rom_data : '0;

  assign busy = (state_q == FETCH) || (state_q == DRAIN);
  assign done = (state_q == FIN);
  assign err  = done && err_q;

  // While stalled, re-present the pending pixel's address so the ROM keeps rom_data on that pixel.
  assign rom_addr = !busy ? '0 : (stall ? wr_raddr_q : cnt_addr);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    err_d      = err_q;
    wr_valid_d = wr_valid_q;
    wr_row_d   = wr_row_q;
    wr_col_d   = wr_col_q;
    wr_raddr_d = wr_raddr_q;
    case (state_q)
      IDLE: begin
        wr_valid_d = 1'b0;
        if (start) begin
          if (lives_valid(lives)) begin
            base_d  = frame_base(lives, 32'(SPRITE_W * SPRITE_H));
            pos_x_d = pos_x;
            pos_y_d = pos_y;
            err_d   = 1'b0;
            state_d = FETCH;
          end else begin
            err_d   = 1'b1;
            state_d = FIN;
          end
        end
      end
      FETCH: begin
        if (!stall) begin
          wr_valid_d = 1'b1;
          wr_row_d   = cnt_row;
          wr_col_d   = cnt_col;
          wr_raddr_d = cnt_addr;
          if (cnt_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!stall) begin
          wr_valid_d = 1'b0;
          state_d    = FIN;
        end
      end
      FIN: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      err_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_raddr_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      err_q      <= err_d;
      wr_valid_q <= wr_valid_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      wr_raddr_q <= wr_raddr_d;
    end
  end

endmodule

// File: tb/tb_car_sprite_blitter.sv
// tb/tb_car_sprite_blitter.sv - randomized scoreboard bench for car_sprite_blitter
module tb_car_sprite_blitter;

  localparam int W  = 80;
  localparam int H  = 104;
  localparam int SW = 640;
  localparam int SH = 480;
  localparam int FW = 8320;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        start;
  logic [2:0]  lives;
  logic [9:0]  pos_x;
  logic [8:0]  pos_y;
  logic        busy, done, err;
  logic [15:0] rom_addr;
  logic [23:0] rom_data;
  logic [18:0] fb_addr;
  logic [23:0] fb_data;
  logic        fb_we;
  logic        fb_ready = 1'b1;

  typedef struct { logic [18:0] a; logic [23:0] d; } wr_t;
  wr_t exp_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0;
  bit in_blit = 0, bp_en = 0;
  int rom_mode = 0;
  int busy_cnt, stall_cnt, done_cnt, done_cyc, wr_count;
  bit done_err, first_set;
  logic [15:0] first_rom, last_rom;
  bit prev_stall = 0;
  logic [15:0] prev_rom = '0;
  logic [18:0] prev_fa;
  logic [23:0] prev_fd;

  car_sprite_blitter dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .start    (start),
    .lives    (lives),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .fb_we    (fb_we),
    .fb_ready (fb_ready)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [23:0] rom_fn(input int mode, input logic [15:0] a);
    case (mode)
      0:       return {8'h3c, a};
      1:       return 24'h0000ff;
      2:       return 24'hffffff;
      default: return ((a % 16'd5) == 16'd0) ? 24'hffffff : {8'h5a, a ^ 16'h1234};
    endcase
  endfunction

  always @(posedge Clk) rom_data <= rom_fn(rom_mode, rom_addr);

  always @(posedge Clk) begin
    #2;
    fb_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic int build_exp(input logic [2:0] lv, input int px, input int py, input int mode);
    int cnt;
    cnt = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int a, x, y;
        logic [23:0] d;
        a = (5 - int'(lv)) * FW + r * W + c;
        d = rom_fn(mode, 16'(a));
        x = px + c;
        y = py + r;
        if (d != 24'hffffff && x < SW && y < SH) begin
          exp_q.push_back('{a: 19'(y * SW + x), d: d});
          cnt++;
        end
      end
    end
    return cnt;
  endfunction

  always @(negedge Clk) begin : mon
    wr_t e;
    if (!Reset_n) begin
      prev_stall = 0;
    end else begin
      if (in_blit) begin
        if (busy) begin
          busy_cnt++;
          if (!first_set) begin first_rom = rom_addr; first_set = 1; end
          last_rom = rom_addr;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc - t0;
          done_err = err;
        end
      end
      if (prev_stall) begin
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== prev_fa || fb_data !== prev_fd) begin
          errors++;
          $display("FAIL stall_hold_fb: fb_we %0b fb_addr %0d fb_data %h, required 1 %0d %h", fb_we, fb_addr, fb_data, prev_fa, prev_fd);
        end
      end
      if (fb_we && !fb_ready) begin
        checks++;
        stall_cnt++;
        if (rom_addr !== prev_rom) begin
          errors++;
          $display("FAIL stall_hold_rom: rom_addr %0d, required %0d", rom_addr, prev_rom);
        end
      end
      if (fb_we && fb_ready) begin
        checks++;
        wr_count++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: fb_addr %0d fb_data %h, required no write", fb_addr, fb_data);
        end else begin
          e = exp_q.pop_front();
          if (fb_addr !== e.a || fb_data !== e.d) begin
            errors++;
            $display("FAIL write_data: fb_addr %0d fb_data %h, required %0d %h", fb_addr, fb_data, e.a, e.d);
          end
        end
      end
      prev_stall = fb_we && !fb_ready;
      prev_rom   = rom_addr;
      prev_fa    = fb_addr;
      prev_fd    = fb_data;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_fb_we"}, fb_we, 0);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_fb_addr"}, fb_addr, 0);
    chk({tag, "_fb_data"}, fb_data, 0);
  endtask

  task automatic run_blit(input string tag, input logic [2:0] lv, input logic [9:0] px,
                          input logic [8:0] py, input int mode, input bit bp, input bit mid,
                          input int exp_n);
    bit ok;
    int n_exp, n;
    ok = (lv >= 3'd1) && (lv <= 3'd5);
    rom_mode = mode;
    bp_en = bp;
    exp_q.delete();
    n_exp = ok ? build_exp(lv, int'(px), int'(py), mode) : 0;
    busy_cnt = 0; stall_cnt = 0; done_cnt = 0; done_cyc = -1; wr_count = 0;
    first_set = 0; done_err = 0;
    lives = lv; pos_x = px; pos_y = py; start = 1'b1;
    t0 = cyc; in_blit = 1;
    @(negedge Clk);
    start = 1'b0;
    lives = 3'($urandom); pos_x = 10'($urandom); pos_y = 9'($urandom);
    n = 0;
    while (done_cnt == 0 && n < 40000) begin
      @(negedge Clk);
      n++;
      if (mid && n == 100) begin start = 1'b1; lives = 3'd2; end
      else if (mid && n == 101) start = 1'b0;
    end
    repeat (4) @(negedge Clk);
    in_blit = 0;
    bp_en = 0;
    chk({tag, " done_count"}, done_cnt, 1);
    chk({tag, " done_cycle"}, done_cyc, ok ? 8322 + stall_cnt : 1);
    chk({tag, " err"}, done_err, ok ? 0 : 1);
    chk({tag, " busy_cycles"}, busy_cnt, ok ? 8321 + stall_cnt : 0);
    chk({tag, " writes"}, wr_count, n_exp);
    chk({tag, " leftover"}, exp_q.size(), 0);
    if (exp_n >= 0) chk({tag, " write_total"}, wr_count, exp_n);
    if (ok) begin
      chk({tag, " first_rom"}, first_rom, (5 - int'(lv)) * FW);
      chk({tag, " last_rom"}, last_rom, (5 - int'(lv)) * FW + FW - 1);
    end else begin
      chk({tag, " rom_active"}, first_set, 0);
    end
  endtask

  task automatic run_reset_mid();
    rom_mode = 0;
    exp_q.delete();
    void'(build_exp(3'd4, 100, 50, 0));
    lives = 3'd4; pos_x = 10'd100; pos_y = 9'd50; start = 1'b1;
    t0 = cyc; in_blit = 0;
    @(negedge Clk);
    start = 1'b0;
    while (cyc - t0 < 4000) @(negedge Clk);
    chk("pre_rst_busy", busy, 1);
    Reset_n = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    exp_q.delete();
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    Reset_n = 1'b0; start = 1'b0; lives = '0; pos_x = '0; pos_y = '0;
    #1;
    check_idle_outputs("reset");
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    run_blit("full", 3'd5, 10'd0, 9'd0, 0, 0, 0, 8320);
    run_blit("lives1", 3'd1, 10'($urandom_range(0, 1023)), 9'($urandom_range(0, 511)), 3, 0, 0, -1);
    run_blit("lives3_mid", 3'd3, 10'($urandom_range(0, 700)), 9'($urandom_range(0, 500)), 0, 0, 1, -1);
    run_blit("clip", 3'd2, 10'd600, 9'd450, 1, 0, 0, 1200);
    run_blit("white", 3'd2, 10'd600, 9'd450, 2, 0, 0, 0);
    run_blit("bp", 3'd4, 10'($urandom_range(0, 560)), 9'($urandom_range(0, 376)), 3, 1, 0, -1);
    run_blit("inv0", 3'd0, 10'd0, 9'd0, 0, 0, 0, 0);
    run_blit("inv6", 3'd6, 10'd10, 9'd10, 0, 0, 0, 0);
    run_blit("inv7", 3'd7, 10'd10, 9'd10, 1, 0, 0, 0);
    run_reset_mid();
    run_blit("after_rst", 3'($urandom_range(1, 5)), 10'($urandom_range(0, 1023)),
             9'($urandom_range(0, 511)), int'($urandom_range(0, 3)), 0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
